// File: rtl/ixayoi_axi_pkg.sv
// Shared AXI encodings and storage entry types for the instruction-fetch ROM responder.
package ixayoi_axi_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
  } ar_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rbuf_entry_t;

  typedef enum logic {ST_IDLE, ST_BURST} eng_state_t;

endpackage

// File: rtl/ixayoi_sync_fifo.sv
// Small synchronous FIFO, power-of-two depth, head visible on rdata.
module ixayoi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    push,
  input  logic [WIDTH-1:0]        wdata,
  input  logic                    pop,
  output logic [WIDTH-1:0]        rdata,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wptr, rptr;
  logic                        full, empty, do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // a pop frees the slot, so push-while-full is legal in the same cycle
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem   <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/ixayoi_axi_rom_responder.sv
// AXI4 read-only burst responder: AR queue -> burst engine -> 1-cycle BRAM -> 2-entry R buffer.
module ixayoi_axi_rom_responder
  import ixayoi_axi_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          MEM_WORDS_LOG2 = 14,
  parameter int          AR_DEPTH       = 4
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [31:0]               si_axi_araddr,
  input  logic [7:0]                si_axi_arlen,
  input  logic [1:0]                si_axi_arburst,
  input  logic                      si_axi_arvalid,
  output logic                      si_axi_arready,
  output logic [31:0]               si_axi_rdata,
  output logic [1:0]                si_axi_rresp,
  output logic                      si_axi_rlast,
  output logic                      si_axi_rvalid,
  input  logic                      si_axi_rready,
  output logic                      mem_en,
  output logic [MEM_WORDS_LOG2-1:0] mem_addr,
  input  logic [31:0]               mem_rdata
);
  localparam int          MW        = MEM_WORDS_LOG2;
  localparam int          AQ_CW     = $clog2(AR_DEPTH) + 1;
  localparam logic [32:0] MEM_BYTES = 33'd4 << MW;

  ar_req_t          ar_in, ar_head;
  logic [AQ_CW-1:0] aq_count;
  logic             aq_push, aq_pop, aq_empty, rst_done;

  eng_state_t       state, state_nxt;
  logic [MW-1:0]    word;
  logic [8:0]       beats;
  logic [1:0]       burst;
  logic             oor, issue;
  logic [31:0]      head_off;
  logic [1:0]       beat_resp;

  logic             rd_vld, rd_last;
  logic [1:0]       rd_resp;
  rbuf_entry_t      rb_in, rb_head;
  logic [1:0]       rb_count;
  logic             rb_pop;
  logic [2:0]       occ;

  // arready stays low until the first edge after reset release
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rst_done <= 1'b0;
    else         rst_done <= 1'b1;
  end

  assign ar_in          = '{addr: si_axi_araddr, len: si_axi_arlen, burst: si_axi_arburst};
  assign si_axi_arready = rst_done && (aq_count != AQ_CW'(AR_DEPTH));
  assign aq_push        = si_axi_arvalid && si_axi_arready;
  assign aq_empty       = (aq_count == '0);

  ixayoi_sync_fifo #(.WIDTH($bits(ar_req_t)), .DEPTH(AR_DEPTH)) u_ar_q (
    .clk    (clk),
    .resetn (resetn),
    .push   (aq_push),
    .wdata  (ar_in),
    .pop    (aq_pop),
    .rdata  (ar_head),
    .count  (aq_count)
  );

  assign head_off  = ar_head.addr - BASE_ADDR;
  // buffered + in-flight beats may not exceed the 2-entry R buffer; a same-cycle pop frees one
  assign occ       = 3'(rb_count) + 3'(rd_vld) - 3'(rb_pop);
  assign beat_resp = burst[1] ? AXI_RESP_SLVERR : (oor ? AXI_RESP_DECERR : AXI_RESP_OKAY);

  always_comb begin
    state_nxt = state;
    aq_pop    = 1'b0;
    issue     = 1'b0;
    case (state)
      ST_IDLE: if (!aq_empty) begin
        aq_pop    = 1'b1;
        state_nxt = ST_BURST;
      end
      ST_BURST: if (occ < 3'd2) begin
        issue = 1'b1;
        if (beats == 9'd1) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      word    <= '0;
      beats   <= '0;
      burst   <= '0;
      oor     <= 1'b0;
      rd_vld  <= 1'b0;
      rd_resp <= '0;
      rd_last <= 1'b0;
    end else begin
      state   <= state_nxt;
      rd_vld  <= issue;
      rd_resp <= beat_resp;
      rd_last <= (beats == 9'd1);
      if (aq_pop) begin
        word  <= MW'(head_off >> 2);
        beats <= {1'b0, ar_head.len} + 9'd1;
        burst <= ar_head.burst;
        oor   <= ({1'b0, head_off} >= MEM_BYTES);
      end else if (issue) begin
        beats <= beats - 9'd1;
        if (burst == AXI_BURST_INCR) begin
          word <= word + 1'b1;
          // stepping off the top word poisons the rest of the burst
          if (&word) oor <= 1'b1;
        end
      end
    end
  end

  assign mem_en   = issue && (beat_resp == AXI_RESP_OKAY);
  assign mem_addr = word;

  assign rb_in  = '{data: (rd_resp == AXI_RESP_OKAY) ? mem_rdata : 32'h0,
                    resp: rd_resp, last: rd_last};
  assign rb_pop = si_axi_rvalid && si_axi_rready;

  ixayoi_sync_fifo #(.WIDTH($bits(rbuf_entry_t)), .DEPTH(2)) u_r_buf (
    .clk    (clk),
    .resetn (resetn),
    .push   (rd_vld),
    .wdata  (rb_in),
    .pop    (rb_pop),
    .rdata  (rb_head),
    .count  (rb_count)
  );

  assign si_axi_rvalid = (rb_count != 2'd0);
  assign si_axi_rdata  = rb_head.data;
  assign si_axi_rresp  = rb_head.resp;
  assign si_axi_rlast  = rb_head.last;

endmodule
